alu_arbiter: RTL and testbench

- Shares the single combinational ALU (ADD/SUB/AND/OR/XOR/SLTU/SLT/SLL/SRL/SRA, ops 0-9) between two requesters, e.g. the execute stage and a branch/address helper.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Accepted operands are registered, driven into the external ALU for one cycle, and the result is registered and returned to the requester that owns it.
- Contention is resolved round-robin; per-requester grant counters are exposed for performance monitoring.

---
 rtl/alu_arbiter_if.sv | 56 +++++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the ALU.
// master = requester/ALU side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_in0;
  logic [WIDTH-1:0] r0_in1;
  logic [OP_W-1:0]  r0_op;
  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_in0;
  logic [WIDTH-1:0] r1_in1;
  logic [OP_W-1:0]  r1_op;
  logic             r0_rsp_valid;
  logic             r0_rsp_ready;
  logic             r1_rsp_valid;
  logic             r1_rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_in0;
  logic [WIDTH-1:0] alu_in1;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  modport master (
    output r0_valid, r0_in0, r0_in1, r0_op,
    output r1_valid, r1_in0, r1_in1, r1_op,
    output r0_rsp_ready, r1_rsp_ready,
    output alu_result, alu_zero,
    input  r0_ready, r1_ready,
    input  r0_rsp_valid, r1_rsp_valid,
    input  rsp_result, rsp_zero, rsp_err,
    input  alu_in0, alu_in1, alu_op,
    input  gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  r0_valid, r0_in0, r0_in1, r0_op,
    input  r1_valid, r1_in0, r1_in1, r1_op,
    input  r0_rsp_ready, r1_rsp_ready,
    input  alu_result, alu_zero,
    output r0_ready, r1_ready,
    output r0_rsp_valid, r1_rsp_valid,
    output rsp_result, rsp_zero, rsp_err,
    output alu_in0, alu_in1, alu_op,
    output gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One transaction at a time: IDLE (grant) -> EXEC (capture) -> RESP (return).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [OP_W-1:0]  OP_MAX  = OP_W'(9);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] in0_q;
  logic [WIDTH-1:0] in1_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             err_q;
  logic             owner;
  logic             last_grant;
  logic             rv0;
  logic             rv1;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             idle;
  logic             win0;
  logic             win1;
  logic             take;

  assign idle = (state == IDLE);
  // On a tie the requester that was not granted last wins.
  assign win0 = idle & bus.r0_valid & (~bus.r1_valid | last_grant);
  assign win1 = idle & bus.r1_valid & (~bus.r0_valid | ~last_grant);
  assign take = owner ? bus.r1_rsp_ready : bus.r0_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in0_q      <= '0;
      in1_q      <= '0;
      op_q       <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win0 | win1) begin
            in0_q      <= win1 ? bus.r1_in0 : bus.r0_in0;
            in1_q      <= win1 ? bus.r1_in1 : bus.r0_in1;
            op_q       <= win1 ? bus.r1_op  : bus.r0_op;
            owner      <= win1;
            last_grant <= win1;
            if (win0 && cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
            if (win1 && cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_q > OP_MAX) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            res_q  <= bus.alu_result;
            zero_q <= bus.alu_zero;
            err_q  <= 1'b0;
          end
          rv0   <= ~owner;
          rv1   <= owner;
          state <= RESP;
        end
        RESP: begin
          if (take) begin
            rv0   <= 1'b0;
            rv1   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_ready     = win0;
  assign bus.r1_ready     = win1;
  assign bus.r0_rsp_valid = rv0;
  assign bus.r1_rsp_valid = rv1;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_err      = err_q;
  assign bus.alu_in0      = in0_q;
  assign bus.alu_in1      = in1_q;
  assign bus.alu_op       = op_q;
  assign bus.gnt_cnt0     = cnt0;
  assign bus.gnt_cnt1     = cnt1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int W    = 32;
  localparam int OW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .OP_W(OW), .CNT_W(CW)) bus ();

  alu_arbiter #(.WIDTH(W), .OP_W(OW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'b0, a < b};
      4'd6: return {31'b0, $signed(a) < $signed(b)};
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  // External ALU; illegal opcodes yield junk the arbiter must discard.
  always_comb begin
    logic [31:0] r;
    r = alu_ref(bus.alu_op, bus.alu_in0, bus.alu_in1);
    if (bus.alu_op > 4'd9) begin
      bus.alu_result = 32'hDEADBEEF;
      bus.alu_zero   = 1'b1;
    end else begin
      bus.alu_result = r;
      bus.alu_zero   = (r == 32'h0);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic [3:0]  op[2];
  logic        rr[2];
  bit          keep;
  bit          rnd;

  int          ph;
  bit          m_last;
  bit          m_own;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic        m_zero, m_err;
  int          m_cnt[2];
  int          n_done;
  int          gq[$];
  logic [31:0] rec_res;
  logic        rec_zero, rec_err, rec_own;

  task automatic apply();
    bus.r0_valid     = v[0];
    bus.r0_in0       = a[0];
    bus.r0_in1       = b[0];
    bus.r0_op        = op[0];
    bus.r1_valid     = v[1];
    bus.r1_in0       = a[1];
    bus.r1_in1       = b[1];
    bus.r1_op        = op[1];
    bus.r0_rsp_ready = rr[0];
    bus.r1_rsp_ready = rr[1];
  endtask

  task automatic model_reset();
    ph       = 0;
    m_last   = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    int g;
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]  = 1'b1;
          a[i]  = $urandom;
          b[i]  = $urandom;
          op[i] = 4'($urandom_range(0, 11));
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
    end
    apply();
    #1;
    g = -1;
    if (ph == 0) begin
      if (v[0] && v[1]) g = m_last ? 0 : 1;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end
    check("r0_ready", 32'(bus.r0_ready), 32'(g == 0));
    check("r1_ready", 32'(bus.r1_ready), 32'(g == 1));
    check("r0_rsp_valid", 32'(bus.r0_rsp_valid), 32'(ph == 2 && !m_own));
    check("r1_rsp_valid", 32'(bus.r1_rsp_valid), 32'(ph == 2 && m_own));
    if (ph == 1) begin
      check("alu_op", 32'(bus.alu_op), 32'(m_op));
      check("alu_in0", bus.alu_in0, m_a);
      check("alu_in1", bus.alu_in1, m_b);
    end
    if (ph == 2) begin
      check("rsp_result", bus.rsp_result, m_res);
      check("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
      check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    end
    check("gnt_cnt0", 32'(bus.gnt_cnt0), 32'(m_cnt[0]));
    check("gnt_cnt1", 32'(bus.gnt_cnt1), 32'(m_cnt[1]));
    if (g >= 0) begin
      m_a    = a[g];
      m_b    = b[g];
      m_op   = op[g];
      m_own  = g[0];
      m_last = g[0];
      if (m_cnt[g] < CMAX) m_cnt[g]++;
      gq.push_back(g);
      ph = 1;
      if (!keep) v[g] = 1'b0;
    end else if (ph == 1) begin
      if (m_op > 4'd9) begin
        m_res  = 32'h0;
        m_zero = 1'b0;
        m_err  = 1'b1;
      end else begin
        m_res  = alu_ref(m_op, m_a, m_b);
        m_zero = (m_res == 32'h0);
        m_err  = 1'b0;
      end
      ph = 2;
    end else if (ph == 2 && rr[m_own]) begin
      rec_res  = m_res;
      rec_zero = m_zero;
      rec_err  = m_err;
      rec_own  = m_own;
      n_done++;
      ph = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    apply();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_result", bus.rsp_result, 32'h0);
    check("rst_alu_op", 32'(bus.alu_op), 32'h0);
    check("rst_alu_in0", bus.alu_in0, 32'h0);
    check("rst_rsp_valid", 32'({bus.r0_rsp_valid, bus.r1_rsp_valid}), 32'h0);
    @(negedge clk);
  endtask

  task automatic txn(input int r, input logic [3:0] o,
                     input logic [31:0] x, input logic [31:0] y);
    int start;
    start = n_done;
    v[r]  = 1'b1;
    op[r] = o;
    a[r]  = x;
    b[r]  = y;
    keep  = 1'b0;
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    for (int k = 0; k < 20 && n_done == start; k++) step();
    check("txn_done", 32'(n_done - start), 32'h1);
  endtask

  initial begin
    v[0] = 0; v[1] = 0; a[0] = 0; a[1] = 0; b[0] = 0; b[1] = 0;
    op[0] = 0; op[1] = 0; rr[0] = 1; rr[1] = 1;
    keep = 0; rnd = 0; n_done = 0;
    model_reset();
    apply();
    do_reset();

    // Contention: both held valid, grants must alternate.
    gq.delete();
    keep = 1'b1;
    v[0] = 1; op[0] = 4'd2; a[0] = 32'hAAAAAAAA; b[0] = 32'h55555555;
    v[1] = 1; op[1] = 4'd3; a[1] = 32'hAAAAAAAA; b[1] = 32'h55555555;
    repeat (12) step();
    v[0] = 0; v[1] = 0; keep = 1'b0;
    check("cont_len", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check("cont_order", 32'(gq[i]), 32'(i % 2));
    check("cont_cnt0", 32'(bus.gnt_cnt0), 32'd2);
    check("cont_cnt1", 32'(bus.gnt_cnt1), 32'd2);

    do_reset();
    txn(1, 4'd1, 32'd5, 32'd5);
    check("sub_res", rec_res, 32'h0);
    check("sub_zero", 32'(rec_zero), 32'h1);
    check("sub_own", 32'(rec_own), 32'h1);
    check("sub_cnt1", 32'(bus.gnt_cnt1), 32'd1);
    check("sub_cnt0", 32'(bus.gnt_cnt0), 32'd0);

    txn(0, 4'd0, 32'h7FFFFFFF, 32'd1);
    check("add_res", rec_res, 32'h80000000);
    check("add_zero", 32'(rec_zero), 32'h0);
    check("add_err", 32'(rec_err), 32'h0);

    txn(0, 4'hF, 32'd1, 32'd1);
    check("ill_err", 32'(rec_err), 32'h1);
    check("ill_res", rec_res, 32'h0);
    check("ill_zero", 32'(rec_zero), 32'h0);
    txn(0, 4'd9, 32'hF0000000, 32'd4);
    check("sra_res", rec_res, 32'hFF000000);
    check("sra_err", 32'(rec_err), 32'h0);

    // Backpressure on r0 while r1 waits.
    v[0] = 1; op[0] = 4'd4; a[0] = 32'h12345678; b[0] = 32'h0F0F0F0F;
    rr[0] = 0;
    step();
    v[1] = 1; op[1] = 4'd7; a[1] = 32'h1; b[1] = 32'd31;
    repeat (6) step();
    check("bp_held", 32'(bus.r0_rsp_valid), 32'h1);
    rr[0] = 1;
    step();
    step();
    check("bp_next", 32'(gq[$]), 32'h1);
    repeat (3) step();

    // Asynchronous reset during EXEC.
    v[0] = 1; op[0] = 4'd0; a[0] = 32'd3; b[0] = 32'd4;
    step();
    #2 rst = 1'b1;
    #1;
    check("rm_rsp_valid", 32'({bus.r0_rsp_valid, bus.r1_rsp_valid}), 32'h0);
    check("rm_alu_op", 32'(bus.alu_op), 32'h0);
    check("rm_cnt", 32'({bus.gnt_cnt0, bus.gnt_cnt1}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    v[0] = 1; v[1] = 1;
    step();
    check("rm_tie", 32'(gq[$]), 32'h0);
    repeat (8) step();

    // Random traffic; the small counters must saturate.
    rnd = 1'b1;
    repeat (600) step();
    rnd = 1'b0;
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
    repeat (4) step();
    check("sat0", 32'(bus.gnt_cnt0), 32'(CMAX));
    check("sat1", 32'(bus.gnt_cnt1), 32'(CMAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
